// File: rtl/rx_iq_pkg.sv
// Shared widths and control-state encoding for the RX IQ collector.
package rx_iq_pkg;

    localparam int IQ_W   = 48;   // {I[23:0], Q[23:0]}
    localparam int CHAN_W = 5;    // receiver index width

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/rx_iq_bank.sv
// NR x IQ_W sample register set: whole-set load, per-index read and a
// full-set view so one bank can be copied into another in a single cycle.
module rx_iq_bank
    import rx_iq_pkg::*;
#(
    parameter int NR = 3
) (
    input  logic              clk_i,
    input  logic              load_i,
    input  logic [IQ_W-1:0]   data_i [0:NR-1],
    input  logic [CHAN_W-1:0] rd_idx_i,
    output logic [IQ_W-1:0]   rd_data_o,
    output logic [IQ_W-1:0]   bank_o [0:NR-1]
);

    logic [IQ_W-1:0] bank_q [0:NR-1];

    // Capture a complete sample set when load is asserted.
    // NOTE: sample storage has no reset; the collector only presents bank
    // contents while streaming, so stale data is never visible.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            for (int i = 0; i < NR; i++) begin
                bank_q[i] <= data_i[i];
            end
        end
    end

    // Per-index read mux; out-of-range indices return zero.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NR; i++) begin
            if (rd_idx_i == CHAN_W'(i)) begin
                rd_data_o = bank_q[i];
            end
        end
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/rx_iq_collector.sv
// Collects coincident per-receiver IQ samples and streams them as one
// AXI-stream beat per active receiver, with a one-deep pending set and a
// saturating count of sets dropped while both banks are busy.
module rx_iq_collector
    import rx_iq_pkg::*;
#(
    parameter int NR    = 3,
    parameter int OVF_W = 8
) (
    input  logic              clk_ad9866,
    input  logic              rst,
    input  logic              enable,
    input  logic [CHAN_W-1:0] last_chan,
    input  logic              rx_data_rdy [0:NR-1],
    input  logic [IQ_W-1:0]   rx_data_iq  [0:NR-1],
    output logic [IQ_W-1:0]   rx_tdata,
    output logic [CHAN_W-1:0] rx_tid,
    output logic              rx_tlast,
    output logic              rx_tvalid,
    input  logic              rx_tready,
    output logic              overflow,
    output logic [OVF_W-1:0]  overflow_cnt
);

    localparam logic [CHAN_W-1:0] MAX_IDX = CHAN_W'(NR - 1);

    state_e            state_q, state_d;
    logic [CHAN_W-1:0] idx_q, idx_d;
    logic [CHAN_W-1:0] act_last_q, act_last_d;    // last index of ACTIVE set
    logic [CHAN_W-1:0] pend_last_q, pend_last_d;  // last index of PENDING set
    logic              pend_full_q, pend_full_d;
    logic              ovf_q, ovf_d;
    logic [OVF_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    logic              capture, beat, final_beat, drop;
    logic              act_load, act_from_pend, pend_load;
    logic [CHAN_W-1:0] cap_last;
    logic [IQ_W-1:0]   act_load_data [0:NR-1];
    logic [IQ_W-1:0]   pend_bank     [0:NR-1];
    logic [IQ_W-1:0]   act_rd_data;
    logic [IQ_W-1:0]   act_bank_unused [0:NR-1];
    logic [IQ_W-1:0]   pend_rd_unused;
    logic              unused_rdy;

    // Strobes are coincident, so receiver 0 alone qualifies a capture.
    assign capture    = enable && rx_data_rdy[0];
    assign cap_last   = (last_chan > MAX_IDX) ? MAX_IDX : last_chan;
    assign beat       = (state_q == SEND) && rx_tready;
    assign final_beat = beat && (idx_q == act_last_q);

    // Fold the unexamined strobes into a sink so they are visibly ignored.
    always_comb begin
        unused_rdy = 1'b0;
        for (int i = 1; i < NR; i++) begin
            unused_rdy = unused_rdy | rx_data_rdy[i];
        end
    end

    // ACTIVE is refilled either from the pending set or straight from the inputs.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            act_load_data[i] = act_from_pend ? pend_bank[i] : rx_data_iq[i];
        end
    end

    rx_iq_bank #(.NR(NR)) u_active (
        .clk_i     (clk_ad9866),
        .load_i    (act_load),
        .data_i    (act_load_data),
        .rd_idx_i  (idx_q),
        .rd_data_o (act_rd_data),
        .bank_o    (act_bank_unused)
    );

    rx_iq_bank #(.NR(NR)) u_pending (
        .clk_i     (clk_ad9866),
        .load_i    (pend_load),
        .data_i    (rx_data_iq),
        .rd_idx_i  ('0),
        .rd_data_o (pend_rd_unused),
        .bank_o    (pend_bank)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_ad9866) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, bank steering, index and overflow decisions.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        act_last_d    = act_last_q;
        pend_last_d   = pend_last_q;
        pend_full_d   = pend_full_q;
        act_load      = 1'b0;
        act_from_pend = 1'b0;
        pend_load     = 1'b0;
        drop          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    act_load   = 1'b1;
                    act_last_d = cap_last;
                    idx_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (final_beat) begin
                    idx_d = '0;
                    if (pend_full_q) begin
                        // Hand the pending set over without an idle cycle.
                        act_load      = 1'b1;
                        act_from_pend = 1'b1;
                        act_last_d    = pend_last_q;
                        if (capture) begin
                            pend_load   = 1'b1;
                            pend_last_d = cap_last;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (capture) begin
                        act_load   = 1'b1;
                        act_last_d = cap_last;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        idx_d = idx_q + CHAN_W'(1);
                    end
                    if (capture) begin
                        if (pend_full_q) begin
                            drop = 1'b1;
                        end else begin
                            pend_load   = 1'b1;
                            pend_last_d = cap_last;
                            pend_full_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d     = drop;
        ovf_cnt_d = ovf_cnt_q;
        if (drop && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
        end
    end

    // Index, set-length, pending flag and overflow registers.
    always_ff @(posedge clk_ad9866) begin
        if (rst) begin
            idx_q       <= '0;
            act_last_q  <= '0;
            pend_last_q <= '0;
            pend_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            idx_q       <= idx_d;
            act_last_q  <= act_last_d;
            pend_last_q <= pend_last_d;
            pend_full_q <= pend_full_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // Stream outputs are driven only while sending; idle shows all zeros.
    always_comb begin
        rx_tvalid = 1'b0;
        rx_tid    = '0;
        rx_tlast  = 1'b0;
        rx_tdata  = '0;
        if (state_q == SEND) begin
            rx_tvalid = 1'b1;
            rx_tid    = idx_q;
            rx_tlast  = (idx_q == act_last_q);
            rx_tdata  = act_rd_data;
        end
    end

    assign overflow     = ovf_q;
    assign overflow_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_rx_iq_collector.sv
// Scoreboard bench for rx_iq_collector: expected beats are queued when a
// set is driven and compared by a monitor as each beat transfers.
module tb_rx_iq_collector;
    import rx_iq_pkg::*;

    localparam int NR    = 3;
    localparam int OVF_W = 2;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [CHAN_W-1:0] last_chan;
    logic              rx_data_rdy [0:NR-1];
    logic [IQ_W-1:0]   rx_data_iq  [0:NR-1];
    logic [IQ_W-1:0]   rx_tdata;
    logic [CHAN_W-1:0] rx_tid;
    logic              rx_tlast;
    logic              rx_tvalid;
    logic              rx_tready;
    logic              overflow;
    logic [OVF_W-1:0]  overflow_cnt;

    rx_iq_collector #(.NR(NR), .OVF_W(OVF_W)) dut (
        .clk_ad9866   (clk),
        .rst          (rst),
        .enable       (enable),
        .last_chan    (last_chan),
        .rx_data_rdy  (rx_data_rdy),
        .rx_data_iq   (rx_data_iq),
        .rx_tdata     (rx_tdata),
        .rx_tid       (rx_tid),
        .rx_tlast     (rx_tlast),
        .rx_tvalid    (rx_tvalid),
        .rx_tready    (rx_tready),
        .overflow     (overflow),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CHAN_W-1:0] tid;
        logic [IQ_W-1:0]   data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the beats a set captured with this base and last_chan must produce.
    task automatic push_set(input logic [IQ_W-1:0] base, input int lc);
        int    nact;
        beat_t b;
        nact = ((lc > NR - 1) ? NR - 1 : lc) + 1;
        for (int i = 0; i < nact; i++) begin
            b.tid  = CHAN_W'(i);
            b.data = base + IQ_W'(i);
            b.last = (i == nact - 1);
            exp_q.push_back(b);
        end
    endtask

    // One-cycle strobe on every receiver with IQ = base + receiver index.
    task automatic pulse(input logic [IQ_W-1:0] base);
        for (int i = 0; i < NR; i++) begin
            rx_data_rdy[i] = 1'b1;
            rx_data_iq[i]  = base + IQ_W'(i);
        end
        step();
        for (int i = 0; i < NR; i++) rx_data_rdy[i] = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        ok = (exp_q.size() == 0);
    endtask

    // Monitor: every transferred beat must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && rx_tvalid && rx_tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got tid=%0d data=%0h last=%0b, required none", rx_tid, rx_tdata, rx_tlast);
            end else begin
                e = exp_q.pop_front();
                if (rx_tid !== e.tid || rx_tdata !== e.data || rx_tlast !== e.last) begin
                    n_fail++;
                    $display("FAIL beat: got tid=%0d data=%0h last=%0b, required tid=%0d data=%0h last=%0b",
                             rx_tid, rx_tdata, rx_tlast, e.tid, e.data, e.last);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        n_checks++; if (rx_tvalid !== 1'b0)   begin n_fail++; $display("FAIL reset_tvalid: got %0b required 0", rx_tvalid); end
        n_checks++; if (rx_tlast !== 1'b0)    begin n_fail++; $display("FAIL reset_tlast: got %0b required 0", rx_tlast); end
        n_checks++; if (rx_tid !== '0)        begin n_fail++; $display("FAIL reset_tid: got %0d required 0", rx_tid); end
        n_checks++; if (rx_tdata !== '0)      begin n_fail++; $display("FAIL reset_tdata: got %0h required 0", rx_tdata); end
        n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %0b required 0", overflow); end
        n_checks++; if (overflow_cnt !== '0)  begin n_fail++; $display("FAIL reset_ovf_cnt: got %0d required 0", overflow_cnt); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit ok;
        rx_tready = 1'b1;
        enable    = 1'b1;
        last_chan = 5'd2;
        push_set(48'h1, 2);
        pulse(48'h1);
        @(negedge clk);
        n_checks++; if (rx_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_latency_tvalid: got %0b required 1", rx_tvalid); end
        n_checks++; if (rx_tid !== 5'd0)    begin n_fail++; $display("FAIL basic_first_tid: got %0d required 0", rx_tid); end
        drain(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_drain: got %0d beats left required 0", exp_q.size()); end
        @(negedge clk);
        n_checks++; if (rx_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_tvalid: got %0b required 0", rx_tvalid); end
        n_checks++; if (rx_tid !== 5'd0 || rx_tlast !== 1'b0) begin n_fail++; $display("FAIL basic_idle_tid_tlast: got %0d/%0b required 0/0", rx_tid, rx_tlast); end
        step();
    endtask

    task automatic test_stall();
        bit ok;
        rx_tready = 1'b1;
        last_chan = 5'd7;
        push_set(48'h10, 7);
        pulse(48'h10);
        step();
        rx_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (rx_tvalid !== 1'b1 || rx_tid !== 5'd1 || rx_tdata !== 48'h11 || rx_tlast !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b tid=%0d data=%0h last=%0b required v=1 tid=1 data=11 last=0",
                         k, rx_tvalid, rx_tid, rx_tdata, rx_tlast);
            end
            step();
        end
        rx_tready = 1'b1;
        drain(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_drain: got %0d beats left required 0", exp_q.size()); end
        @(negedge clk);
        n_checks++; if (rx_tvalid !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %0b required 0", rx_tvalid); end
        step();
    endtask

    task automatic test_overflow();
        bit ok;
        rx_tready = 1'b0;
        last_chan = 5'd2;
        push_set(48'h20, 2);
        pulse(48'h20);
        step();
        push_set(48'h30, 2);
        pulse(48'h30);
        step();
        pulse(48'h40);
        @(negedge clk);
        n_checks++; if (overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_pulse: got %0b required 1", overflow); end
        n_checks++; if (overflow_cnt !== 2'd1) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 1", overflow_cnt); end
        step();
        @(negedge clk);
        n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL ovf_pulse_width: got %0b required 0", overflow); end
        step();
        rx_tready = 1'b1;
        drain(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_drain: got %0d beats left required 0", exp_q.size()); end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        rx_tready = 1'b1;
        last_chan = 5'd2;
        push_set(48'h50, 2);
        pulse(48'h50);
        step();
        step();
        push_set(48'h60, 2);
        pulse(48'h60);
        @(negedge clk);
        n_checks++;
        if (rx_tvalid !== 1'b1 || rx_tid !== 5'd0 || rx_tdata !== 48'h60) begin
            n_fail++;
            $display("FAIL b2b_next_set: got v=%0b tid=%0d data=%0h required v=1 tid=0 data=60", rx_tvalid, rx_tid, rx_tdata);
        end
        drain(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d beats left required 0", exp_q.size()); end
        step();
    endtask

    task automatic test_pend_handoff();
        bit ok;
        rx_tready = 1'b0;
        last_chan = 5'd2;
        push_set(48'h70, 2);
        pulse(48'h70);
        push_set(48'h80, 2);
        pulse(48'h80);
        rx_tready = 1'b1;
        step();
        step();
        push_set(48'h90, 2);
        pulse(48'h90);
        @(negedge clk);
        n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL handoff_no_ovf: got %0b required 0", overflow); end
        n_checks++; if (overflow_cnt !== 2'd1) begin n_fail++; $display("FAIL handoff_ovf_cnt: got %0d required 1", overflow_cnt); end
        n_checks++;
        if (rx_tid !== 5'd0 || rx_tdata !== 48'h80) begin
            n_fail++;
            $display("FAIL handoff_pending_first: got tid=%0d data=%0h required tid=0 data=80", rx_tid, rx_tdata);
        end
        drain(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL handoff_drain: got %0d beats left required 0", exp_q.size()); end
        step();
    endtask

    task automatic test_enable();
        bit ok;
        enable    = 1'b0;
        rx_tready = 1'b1;
        last_chan = 5'd2;
        for (int k = 0; k < 3; k++) begin
            pulse(48'hA0 + IQ_W'(k));
            @(negedge clk);
            n_checks++;
            if (rx_tvalid !== 1'b0 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_off[%0d]: got v=%0b ovf=%0b required 0/0", k, rx_tvalid, overflow);
            end
        end
        // Sets already held keep draining while new strobes are ignored.
        enable    = 1'b1;
        rx_tready = 1'b0;
        push_set(48'hB0, 2);
        pulse(48'hB0);
        push_set(48'hC0, 2);
        pulse(48'hC0);
        enable = 1'b0;
        pulse(48'hD0);
        @(negedge clk);
        n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL enable_off_no_ovf: got %0b required 0", overflow); end
        n_checks++; if (overflow_cnt !== 2'd1) begin n_fail++; $display("FAIL enable_off_cnt: got %0d required 1", overflow_cnt); end
        step();
        rx_tready = 1'b1;
        drain(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL enable_off_drain: got %0d beats left required 0", exp_q.size()); end
        step();
        // Set length is fixed at capture even if last_chan moves afterwards.
        enable    = 1'b1;
        last_chan = 5'd1;
        push_set(48'hE0, 1);
        pulse(48'hE0);
        last_chan = 5'd2;
        drain(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL latch_nact_drain: got %0d beats left required 0", exp_q.size()); end
        @(negedge clk);
        n_checks++; if (rx_tvalid !== 1'b0) begin n_fail++; $display("FAIL latch_nact_idle: got %0b required 0", rx_tvalid); end
        step();
    endtask

    task automatic test_saturate_and_reset();
        int exp_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        enable    = 1'b1;
        rx_tready = 1'b0;
        last_chan = 5'd2;
        push_set(48'h100, 2);
        pulse(48'h100);
        push_set(48'h110, 2);
        pulse(48'h110);
        for (int k = 1; k <= 5; k++) begin
            pulse(48'h200 + IQ_W'(k));
            @(negedge clk);
            exp_cnt = (k > 3) ? 3 : k;
            n_checks++;
            if (overflow !== 1'b1 || overflow_cnt !== OVF_W'(exp_cnt)) begin
                n_fail++;
                $display("FAIL sat_drop[%0d]: got ovf=%0b cnt=%0d required ovf=1 cnt=%0d", k, overflow, overflow_cnt, exp_cnt);
            end
        end
        step();
        rx_tready = 1'b1;
        step();
        // Reset mid-set, with a coincident capture that must be discarded.
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rx_data_rdy[i] = 1'b1;
            rx_data_iq[i]  = 48'h300 + IQ_W'(i);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) rx_data_rdy[i] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_checks++; if (rx_tvalid !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_tvalid: got %0b required 0", rx_tvalid); end
        n_checks++; if (overflow_cnt !== '0)   begin n_fail++; $display("FAIL rst_mid_cnt: got %0d required 0", overflow_cnt); end
        n_checks++; if (rx_tdata !== '0)       begin n_fail++; $display("FAIL rst_mid_tdata: got %0h required 0", rx_tdata); end
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            n_checks++; if (rx_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_no_partial[%0d]: got %0b required 0", k, rx_tvalid); end
        end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        last_chan = '0;
        rx_tready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rx_data_rdy[i] = 1'b0;
            rx_data_iq[i]  = '0;
        end
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_back_to_back();
        test_pend_handoff();
        test_enable();
        test_saturate_and_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d beats required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rx_iq_collector.md
RX_IQ_COLLECTOR -- requirements
Module: rx_iq_collector

Interface
REQ-001 Parameter NR, default 3, number of receiver inputs, legal range 1..12.
REQ-002 Parameter OVF_W, default 8, width of the overflow counter.
REQ-003 clk_ad9866  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  1 = accept new sample sets; 0 = ignore rx_data_rdy.
REQ-006 last_chan  in  5  index of the highest active receiver.
REQ-007 rx_data_rdy  in  [0:NR-1]x1  per-receiver sample strobe; all strobes are coincident.
REQ-008 rx_data_iq  in  [0:NR-1]x48  per-receiver {I[23:0],Q[23:0]}, valid while its strobe is high.
REQ-009 rx_tdata  out  48  IQ sample of channel rx_tid.
REQ-010 rx_tid  out  5  receiver index of the current beat.
REQ-011 rx_tlast  out  1  high on the last active channel of a set.
REQ-012 rx_tvalid  out  1  AXI-stream valid.
REQ-013 rx_tready  in  1  AXI-stream ready from the packetizer.
REQ-014 overflow  out  1  one-cycle pulse when a sample set is dropped.
REQ-015 overflow_cnt  out  OVF_W  saturating count of dropped sets.

Function
REQ-016 Only rx_data_rdy[0] triggers a capture; the other strobes are not examined.
REQ-017 At capture, nact = min(last_chan, NR-1)+1, latched with the set; later last_chan changes do not affect that set.
REQ-018 Storage is two banks: ACTIVE (being streamed) and PENDING (one-deep, flag pend_full).
REQ-019 States: IDLE, SEND; idx counts 0..nact-1 within SEND.
REQ-020 IDLE, capture: load all NR inputs into ACTIVE, idx=0, go to SEND; rx_tvalid=1 on the next cycle (latency 1).
REQ-021 SEND: rx_tvalid=1, rx_tdata=ACTIVE[idx], rx_tid=idx, rx_tlast=(idx==nact-1).
REQ-022 A beat transfers when rx_tvalid and rx_tready are both high; idx then increments.
REQ-023 While rx_tvalid=1 and rx_tready=0, rx_tdata, rx_tid and rx_tlast hold stable.
REQ-024 SEND, capture, not the final beat, pend_full=0: load PENDING and set pend_full.
REQ-025 SEND, capture, pend_full=1: drop the new set, pulse overflow, increment overflow_cnt (saturate at all-ones).
REQ-026 Final beat with pend_full=1: PENDING moves to ACTIVE, idx=0, stay in SEND, clear pend_full, with no idle cycle.
REQ-027 Final beat with pend_full=0 and a simultaneous capture: load inputs into ACTIVE, idx=0, stay in SEND.
REQ-028 Final beat with pend_full=1 and a simultaneous capture: PENDING moves to ACTIVE and the inputs load PENDING; no overflow.
REQ-029 Final beat with no pending set and no capture: go to IDLE; rx_tvalid=0 next cycle.
REQ-030 enable=0: captures are ignored and never counted as overflow; sets in flight and PENDING still drain.
REQ-031 In IDLE: rx_tvalid=0, rx_tlast=0, rx_tid=0.

Reset
REQ-032 rst=1 in any cycle: next cycle state=IDLE, idx=0, pend_full=0, rx_tvalid=0, rx_tlast=0, rx_tid=0, rx_tdata=0, overflow=0, overflow_cnt=0.
REQ-033 Reset mid-set abandons the remaining beats; no partial beat appears after reset.
REQ-034 A capture coincident with rst is discarded.
REQ-035 Bank data registers carry no reset requirement beyond REQ-032.

Structure
REQ-036 Package rx_iq_pkg holds IQ_W=48, CHAN_W=5, and the state enum {IDLE,SEND}.
REQ-037 One sub-module, rx_iq_bank (NR x IQ_W register set with load and per-index read), is instantiated twice (ACTIVE, PENDING).
REQ-038 Control FSM, idx/nact logic and overflow counter live in rx_iq_collector.

Verification
REQ-039 NR=3, last_chan=2, rx_tready=1, rdy pulse with IQ=0x000001..0x000003: beats tid 0,1,2 on cycles N+1..N+3, tlast only on tid 2.
REQ-040 last_chan=7, NR=3: nact=3; rx_tready low 5 cycles mid-set: tdata/tid frozen, no beat lost or duplicated.
REQ-041 rx_tready=0, three rdy pulses: 1st to ACTIVE, 2nd to PENDING, 3rd dropped with overflow pulse and overflow_cnt=1; release ready: 6 beats, sets 1 then 2.
REQ-042 rdy[0] coincident with the final accepted beat, pend_full=0: next cycle tid=0 of the new set, tvalid never drops.
REQ-043 OVF_W=2, force 5 drops: overflow_cnt sticks at 3; rst mid-set: next cycle tvalid=0, overflow_cnt=0.
REQ-044 enable=0 with rdy pulses: no beats, no overflow; last_chan changed mid-set does not alter that set's tlast position.
